// File: rtl/joybus_pkg.sv
// rtl/joybus_pkg.sv - shared joybus receiver types and constants
package joybus_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    BIT_LOW  = 3'd2,
    BIT_HIGH = 3'd3,
    STOP     = 3'd4
  } rx_state_t;

  localparam int US_PER_SAMPLE   = 2;
  localparam int CNTLR_RESP_BITS = 64;

endpackage

// File: rtl/jb_sync.sv
// rtl/jb_sync.sv - 2-flop line synchronizer with registered edge strobes
module jb_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic fall,
  output logic rise
);

  logic meta;

  // The line idles high, so the flops reset high to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      dout <= 1'b1;
      fall <= 1'b0;
      rise <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
      fall <= dout & ~meta;
      rise <= ~dout & meta;
    end
  end

endmodule

// File: rtl/gc_cntlr_rx.sv
// rtl/gc_cntlr_rx.sv - joybus receiver for one 64-bit controller response
module gc_cntlr_rx
  import joybus_pkg::*;
#(
  parameter int CLK_PER_US     = 50,
  parameter int BIT_TIMEOUT_US = 8,
  parameter int ARM_TIMEOUT_US = 200
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       JB_RX,
  input  logic                       rx_start,
  output logic [CNTLR_RESP_BITS-1:0] cntlr_data,
  output logic                       cntlr_data_rdy,
  output logic                       rx_err,
  output logic                       busy
);

  localparam logic [15:0] SAMPLE_CYC = 16'(US_PER_SAMPLE * CLK_PER_US);
  // Compared against the current count so the pulse lands on the cycle the count reaches the limit.
  localparam logic [15:0] ARM_LAST   = 16'(ARM_TIMEOUT_US * CLK_PER_US - 1);
  localparam logic [15:0] BIT_LAST   = 16'(BIT_TIMEOUT_US * CLK_PER_US - 1);
  localparam logic [6:0]  LAST_BIT   = 7'(CNTLR_RESP_BITS);

  rx_state_t                  state, state_n;
  logic [15:0]                cnt, cnt_n, cnt_inc;
  logic [6:0]                 bit_cnt, bit_cnt_n;
  logic [CNTLR_RESP_BITS-1:0] shreg, shreg_n, data_n;
  logic                       rdy_n, err_n;
  logic                       line, fall, rise, bit_to;

  jb_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (JB_RX),
    .dout (line),
    .fall (fall),
    .rise (rise)
  );

  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign bit_to  = (cnt >= BIT_LAST);
  assign busy    = (state != IDLE);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt_inc;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    data_n    = cntlr_data;
    rdy_n     = 1'b0;
    err_n     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (rx_start) begin
          state_n   = ARMED;
          bit_cnt_n = '0;
          shreg_n   = '0;
        end
      end
      ARMED: begin
        if (cnt >= ARM_LAST) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else if (fall) begin
          cnt_n   = '0;
          state_n = BIT_LOW;
        end
      end
      BIT_LOW: begin
        if (bit_to) begin
          err_n     = 1'b1;
          state_n   = IDLE;
          shreg_n   = '0;
          bit_cnt_n = '0;
        end else if (cnt == SAMPLE_CYC) begin
          shreg_n   = {shreg[CNTLR_RESP_BITS-2:0], line};
          bit_cnt_n = bit_cnt + 7'd1;
          state_n   = BIT_HIGH;
        end
      end
      BIT_HIGH: begin
        // A timeout takes priority over a falling edge seen in the same cycle.
        if (bit_to) begin
          err_n     = 1'b1;
          state_n   = IDLE;
          shreg_n   = '0;
          bit_cnt_n = '0;
        end else if (fall) begin
          cnt_n   = '0;
          state_n = (bit_cnt == LAST_BIT) ? STOP : BIT_LOW;
        end
      end
      STOP: begin
        if (bit_to) begin
          err_n     = 1'b1;
          state_n   = IDLE;
          shreg_n   = '0;
          bit_cnt_n = '0;
        end else if (rise) begin
          data_n  = shreg;
          rdy_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_cnt        <= '0;
      shreg          <= '0;
      cntlr_data     <= '0;
      cntlr_data_rdy <= 1'b0;
      rx_err         <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      bit_cnt        <= bit_cnt_n;
      shreg          <= shreg_n;
      cntlr_data     <= data_n;
      cntlr_data_rdy <= rdy_n;
      rx_err         <= err_n;
    end
  end

endmodule

// File: tb/tb_gc_cntlr_rx.sv
// tb/tb_gc_cntlr_rx.sv - self-checking bench for gc_cntlr_rx
module tb_gc_cntlr_rx;

  localparam int CPU        = 50;
  localparam int BIT_TO_CYC = 8 * CPU;
  localparam int ARM_TO_CYC = 200 * CPU;
  localparam int SYNC_LAT   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jb = 1'b1;
  logic        rx_start = 1'b0;
  logic [63:0] data;
  logic        rdy, err, busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rdy_cnt = 0, err_cnt = 0;
  int rdy_cyc = -1, err_cyc = -1;
  int last_fall_cyc = 0, last_rise_cyc = 0;
  logic [63:0] exp_data = 64'd0;
  logic [63:0] prev_data = 64'd0;

  gc_cntlr_rx dut (
    .clk            (clk),
    .rst            (rst),
    .JB_RX          (jb),
    .rx_start       (rx_start),
    .cntlr_data     (data),
    .cntlr_data_rdy (rdy),
    .rx_err         (err),
    .busy           (busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse bookkeeping plus the always-true output rules.
  always @(negedge clk) begin
    if (!rst) begin
      if (rdy || err) begin
        check("pulse_exclusive", 64'(rdy & err), 64'd0);
        check("busy_low_at_pulse", 64'(busy), 64'd0);
      end
      if (data !== prev_data) check("data_moves_only_with_rdy", 64'(rdy), 64'd1);
    end
    if (rdy) begin rdy_cnt++; rdy_cyc = cyc; end
    if (err) begin err_cnt++; err_cyc = cyc; end
    prev_data = data;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_bit(input logic b);
    jb = 1'b0; last_fall_cyc = cyc;
    tick(b ? CPU : 3 * CPU);
    jb = 1'b1;
    tick(b ? 3 * CPU : CPU);
  endtask

  task automatic send_bits(input logic [63:0] d, input int first, input int last);
    for (int i = first; i < last; i++) send_bit(d[63-i]);
  endtask

  task automatic send_stop(input int us);
    jb = 1'b0; last_fall_cyc = cyc;
    tick(us * CPU);
    jb = 1'b1; last_rise_cyc = cyc;
  endtask

  task automatic start_rx();
    rx_start = 1'b1;
    tick(1);
    rx_start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [63:0] frame, input int stop_us, input int gap_us);
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    start_rx();
    check({tag, "_busy"}, 64'(busy), 64'd1);
    tick(gap_us * CPU);
    send_bits(frame, 0, 64);
    send_stop(stop_us);
    tick(10);
    exp_data = frame;
    check({tag, "_rdy_count"}, 64'(rdy_cnt - r0), 64'd1);
    check({tag, "_err_count"}, 64'(err_cnt - e0), 64'd0);
    check({tag, "_data"}, data, exp_data);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_rdy_latency"}, 64'(rdy_cyc - last_rise_cyc), 64'(SYNC_LAT));
  endtask

  initial begin
    int r0, e0, a0;
    logic [63:0] rnd;

    tick(3);
    check("reset_data", data, 64'd0);
    check("reset_rdy", 64'(rdy), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick(5);

    run_frame("basic", 64'h0080_8080_8080_8080, 2, 0);

    // Armed with a quiet line.
    e0 = err_cnt; a0 = cyc;
    start_rx();
    tick(ARM_TO_CYC + 20);
    check("arm_to_count", 64'(err_cnt - e0), 64'd1);
    check("arm_to_cycles", 64'(err_cyc - (a0 + 1)), 64'(ARM_TO_CYC));
    check("arm_to_data", data, exp_data);
    check("arm_to_busy", 64'(busy), 64'd0);

    // Frame stalls after 30 bits.
    rnd = {$urandom(), $urandom()};
    e0 = err_cnt; r0 = rdy_cnt;
    start_rx();
    send_bits(rnd, 0, 30);
    tick(10 * CPU);
    check("bit_to_count", 64'(err_cnt - e0), 64'd1);
    check("bit_to_cycles", 64'(err_cyc - last_fall_cyc), 64'(BIT_TO_CYC + SYNC_LAT));
    check("bit_to_no_rdy", 64'(rdy_cnt - r0), 64'd0);
    check("bit_to_data", data, exp_data);
    check("bit_to_busy", 64'(busy), 64'd0);
    run_frame("ones", 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);

    // Reset in the middle of a frame.
    rnd = {$urandom(), $urandom()};
    r0 = rdy_cnt; e0 = err_cnt;
    start_rx();
    send_bits(rnd, 0, 40);
    rst = 1'b1;
    tick(2);
    exp_data = 64'd0;
    check("midrst_data", data, exp_data);
    check("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    send_bits(rnd, 40, 64);
    send_stop(2);
    tick(10);
    check("midrst_no_rdy", 64'(rdy_cnt - r0), 64'd0);
    check("midrst_no_err", 64'(err_cnt - e0), 64'd0);
    check("midrst_data_after", data, exp_data);
    check("midrst_busy_after", 64'(busy), 64'd0);

    // Second rx_start while busy must not restart the frame.
    r0 = rdy_cnt; e0 = err_cnt;
    start_rx();
    send_bits(64'hA5A5_A5A5_5A5A_5A5A, 0, 32);
    start_rx();
    check("rearm_busy", 64'(busy), 64'd1);
    send_bits(64'hA5A5_A5A5_5A5A_5A5A, 32, 64);
    send_stop(1);
    tick(10);
    exp_data = 64'hA5A5_A5A5_5A5A_5A5A;
    check("rearm_rdy_count", 64'(rdy_cnt - r0), 64'd1);
    check("rearm_err_count", 64'(err_cnt - e0), 64'd0);
    check("rearm_data", data, exp_data);
    check("rearm_busy_after", 64'(busy), 64'd0);

    rnd = {$urandom(), $urandom()};
    run_frame("random", rnd, int'($urandom_range(1, 2)), int'($urandom_range(1, 20)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
